// File: rtl/uart_pkg.sv
// Shared UART constants: default rates and frame layout (start + data + stop).
package uart_pkg;
  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 9600;
  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
  localparam int CNT0_W     = 16;
  localparam int CNT1_W     = 4;

  function automatic int bps_cnt(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line in, recovered byte and strobes out.
interface uart_rx_if;
  logic       din;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;

  // master: drives the line and consumes the recovered bytes
  modport master (output din, input dout, input dout_vld, input frame_err);
  // slave: the receiver itself
  modport slave  (input din, output dout, output dout_vld, output frame_err);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer plus an edge flop for an asynchronous input.
// Flops reset to RST_VAL so an idle-high line produces no spurious edge.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);
  logic r_s1, r_s2, r_s3;

  // shift the async level through the synchronizer and edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_fall = r_s3 & ~r_s2;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling. The stop bit is only sampled at
// its middle and the FSM returns to IDLE right there, so a transmitter with
// a half-length stop bit can be followed without losing the next start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK     = CLK_HZ,
  parameter int BPS     = BAUD,
  parameter int BPS_CNT = bps_cnt(CLK, BPS)
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [CNT0_W-1:0] C_MID  = CNT0_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT0_W-1:0] C_END  = CNT0_W'(BPS_CNT - 1);
  localparam logic [CNT1_W-1:0] C_LAST = CNT1_W'(DATA_BITS - 1);

  state_t                 r_state;
  logic [CNT0_W-1:0]      r_cnt0;
  logic [CNT1_W-1:0]      r_cnt1;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_dout;
  logic                   r_dout_vld;
  logic                   r_frame_err;

  logic w_rx, w_fall, w_mid, w_end;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.din),
    .o_sync  (w_rx),
    .o_fall  (w_fall)
  );

  assign w_mid = (r_cnt0 == C_MID);
  assign w_end = (r_cnt0 == C_END);

  // frame FSM with bit timer, data shift register and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_dout_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dout_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt0 <= '0;
          r_cnt1 <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (w_mid && w_rx) begin
            // line back high at mid start bit: treat as a glitch
            r_cnt0  <= '0;
            r_state <= S_IDLE;
          end else if (w_end) begin
            r_cnt0  <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt0 <= r_cnt0 + 1'b1;
          end
        end
        S_DATA: begin
          if (w_mid) r_shift[r_cnt1[2:0]] <= w_rx;
          if (w_end) begin
            r_cnt0 <= '0;
            if (r_cnt1 == C_LAST) begin
              r_cnt1  <= '0;
              r_state <= S_STOP;
            end else begin
              r_cnt1 <= r_cnt1 + 1'b1;
            end
          end else begin
            r_cnt0 <= r_cnt0 + 1'b1;
          end
        end
        S_STOP: begin
          if (w_mid) begin
            r_cnt0  <= '0;
            r_state <= S_IDLE;
            if (w_rx) begin
              r_dout     <= r_shift;
              r_dout_vld <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt0 <= r_cnt0 + 1'b1;
          end
        end
        default: begin
          r_cnt0  <= '0;
          r_cnt1  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout      = r_dout;
  assign bus.dout_vld  = r_dout_vld;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, monitors
// pop and compare kind, byte and arrival cycle.
module tb_uart_rx;
  localparam int B  = 10;    // CLK=1000, BPS=100
  localparam int BD = 5208;  // default parameters

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  uart_rx_if bus0();
  uart_rx_if bus1();

  uart_rx #(.CLK(1000), .BPS(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  uart_rx dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endfunction

  // monitor for the BPS_CNT=10 receiver
  always @(negedge clk) begin
    if (bus0.dout_vld || bus0.frame_err) begin
      if (q0.size() == 0) begin
        chk("unexpected_strobe0", {30'd0, bus0.dout_vld, bus0.frame_err}, 0);
      end else begin
        e0 = q0.pop_front();
        chk("kind0", {30'd0, bus0.dout_vld, bus0.frame_err}, e0.err ? 1 : 2);
        chk("data0", int'(bus0.dout), int'(e0.data));
        chk("cycle0", cyc, e0.cyc);
      end
    end
  end

  // monitor for the default-parameter receiver
  always @(negedge clk) begin
    if (bus1.dout_vld || bus1.frame_err) begin
      if (q1.size() == 0) begin
        chk("unexpected_strobe1", {30'd0, bus1.dout_vld, bus1.frame_err}, 0);
      end else begin
        e1 = q1.pop_front();
        chk("kind1", {30'd0, bus1.dout_vld, bus1.frame_err}, e1.err ? 1 : 2);
        chk("data1", int'(bus1.dout), int'(e1.data));
        chk("cycle1", cyc, e1.cyc);
      end
    end
  end

  task automatic setd(input int w, input logic v);
    if (w == 0) bus0.din = v;
    else        bus1.din = v;
  endtask

  // Drive one frame; the next frame's start is driven one clock after the
  // stop period, so stop length on the line is sclk+1 clocks.
  task automatic send(input int w, input logic [7:0] b, input logic sv,
                      input int sclk, input int bc, input logic [7:0] prev);
    exp_t e;
    int   ec;
    @(negedge clk);
    ec     = cyc + 1;  // edge at which r1 captures the start bit
    e.err  = !sv;
    e.data = sv ? b : prev;
    e.cyc  = ec + 9 * bc + bc / 2 + 2;
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
    setd(w, 1'b0);
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setd(w, b[i]);
      repeat (bc) @(negedge clk);
    end
    setd(w, sv);
    repeat (sclk) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++)
      @(negedge clk);
    chk(name, q0.size() + q1.size(), 0);
  endtask

  initial begin
    bus0.din = 1'b1;
    bus1.din = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout0", int'(bus0.dout), 0);
    chk("rst_vld0", int'(bus0.dout_vld), 0);
    chk("rst_ferr0", int'(bus0.frame_err), 0);
    chk("rst_dout1", int'(bus1.dout), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single frame, full stop bit
    send(0, 8'h55, 1'b1, B, B, 8'h00);
    repeat (2 * B) @(negedge clk);

    // back-to-back with half-bit stop
    send(0, 8'hA5, 1'b1, B / 2, B, 8'h55);
    send(0, 8'h3C, 1'b1, B, B, 8'hA5);
    repeat (2 * B) @(negedge clk);

    // 3-clock glitch must be rejected, then a normal frame
    bus0.din = 1'b0;
    repeat (3) @(negedge clk);
    bus0.din = 1'b1;
    repeat (12) @(negedge clk);
    send(0, 8'h0F, 1'b1, B, B, 8'h3C);
    repeat (2 * B) @(negedge clk);

    // stop bit low, line held low, then recovery
    send(0, 8'hC3, 1'b0, B, B, 8'h0F);
    repeat (30) @(negedge clk);
    bus0.din = 1'b1;
    repeat (B) @(negedge clk);
    send(0, 8'h81, 1'b1, B, B, 8'hC3);
    drain("drain_a");
    chk("dout_after_81", int'(bus0.dout), 8'h81);

    // reset during data bit 4 (line high during bit 4)
    @(negedge clk);
    bus0.din = 1'b0;
    repeat (5 * B) @(negedge clk);
    bus0.din = 1'b1;
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_dout", int'(bus0.dout), 0);
    chk("midrst_vld", int'(bus0.dout_vld), 0);
    chk("midrst_ferr", int'(bus0.frame_err), 0);
    rst_n = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("post_rst_dout", int'(bus0.dout), 0);
    send(0, 8'hFF, 1'b1, B, B, 8'h00);

    // default parameters, exact latency
    send(1, 8'h00, 1'b1, BD, BD, 8'h00);
    drain("drain_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
